// File: rtl/ecs_sample_averager.sv
// ecs_sample_averager: latches X/Y readings from the eddy-current SPI master on
// each rising edge of its done level, applies saturating offset correction and
// block-averages 2^avg_log2 corrected samples per axis.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | averaging disabled, accumulators held at zero
// ACC    | accumulating the current window
// EMIT   | one cycle: publish window average, start the next window
module ecs_sample_averager (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [17:0] sensor_data_x,
    input  logic [17:0] sensor_data_y,
    input  logic        enable,
    input  logic        clear,
    input  logic [2:0]  avg_log2,
    input  logic [17:0] offset_x,
    input  logic [17:0] offset_y,
    output logic [17:0] last_x,
    output logic [17:0] last_y,
    output logic [17:0] avg_x,
    output logic [17:0] avg_y,
    output logic        avg_valid,
    output logic [15:0] sample_cnt,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic               done_d_q, done_d_d;
    logic               armed_q, armed_d;
    logic               s1_valid_q, s1_valid_d;
    logic [17:0]        last_x_q, last_x_d;
    logic [17:0]        last_y_q, last_y_d;
    logic [15:0]        sample_cnt_q, sample_cnt_d;
    logic [1:0]         state_q, state_d;
    logic signed [25:0] acc_x_q, acc_x_d;
    logic signed [25:0] acc_y_q, acc_y_d;
    logic [7:0]         win_cnt_q, win_cnt_d;
    logic [2:0]         n_lat_q, n_lat_d;
    logic [17:0]        avg_x_q, avg_x_d;
    logic [17:0]        avg_y_q, avg_y_d;
    logic               avg_valid_q, avg_valid_d;

    logic               sample;
    logic [7:0]         win_inc;
    logic [8:0]         win_target;
    logic signed [25:0] ext_x, ext_y;

    // Subtract offset in 19 bits; the two top bits disagree only on overflow.
    function automatic logic [17:0] sat_sub(input logic [17:0] a, input logic [17:0] b);
        logic [18:0] d;
        d = {a[17], a} - {b[17], b};
        if (d[18] != d[17]) begin
            return d[18] ? 18'h20000 : 18'h1FFFF;
        end
        return d[17:0];
    endfunction

    // armed_q blocks a done level that was already high when reset released.
    assign sample     = done & ~done_d_q & armed_q;
    assign win_inc    = win_cnt_q + 8'd1;
    assign win_target = 9'd1 << n_lat_q;
    assign ext_x      = {{8{last_x_q[17]}}, last_x_q};
    assign ext_y      = {{8{last_y_q[17]}}, last_y_q};

    // Edge detect and stage 1: offset correction and sample counting.
    always_comb begin
        done_d_d     = done;
        armed_d      = armed_q | ~done;
        s1_valid_d   = 1'b0;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        sample_cnt_d = sample_cnt_q;
        if (clear) begin
            last_x_d     = 18'd0;
            last_y_d     = 18'd0;
            sample_cnt_d = 16'd0;
        end else if (sample && enable) begin
            last_x_d     = sat_sub(sensor_data_x, offset_x);
            last_y_d     = sat_sub(sensor_data_y, offset_y);
            sample_cnt_d = sample_cnt_q + 16'd1;
            s1_valid_d   = 1'b1;
        end
    end

    // Stage 2 accumulation and window state machine.
    always_comb begin
        state_d     = state_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        win_cnt_d   = win_cnt_q;
        n_lat_d     = n_lat_q;
        avg_x_d     = avg_x_q;
        avg_y_d     = avg_y_q;
        avg_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_x_d   = 26'sd0;
                acc_y_d   = 26'sd0;
                win_cnt_d = 8'd0;
                if (enable) begin
                    state_d = S_ACC;
                    n_lat_d = avg_log2;
                end
            end
            S_ACC: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    acc_x_d   = 26'sd0;
                    acc_y_d   = 26'sd0;
                    win_cnt_d = 8'd0;
                end else if (s1_valid_q) begin
                    acc_x_d   = acc_x_q + ext_x;
                    acc_y_d   = acc_y_q + ext_y;
                    win_cnt_d = win_inc;
                    if ({1'b0, win_inc} == win_target) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                // The window sum of 2^n 18-bit values shifted by n always fits 18 bits.
                avg_x_d     = 18'(acc_x_q >>> n_lat_q);
                avg_y_d     = 18'(acc_y_q >>> n_lat_q);
                avg_valid_d = 1'b1;
                acc_x_d     = 26'sd0;
                acc_y_d     = 26'sd0;
                win_cnt_d   = 8'd0;
                n_lat_d     = avg_log2;
                if (enable) begin
                    state_d = S_ACC;
                    if (s1_valid_q) begin
                        acc_x_d   = ext_x;
                        acc_y_d   = ext_y;
                        win_cnt_d = 8'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                acc_x_d   = 26'sd0;
                acc_y_d   = 26'sd0;
                win_cnt_d = 8'd0;
            end
        endcase
        if (clear) begin
            state_d     = S_IDLE;
            acc_x_d     = 26'sd0;
            acc_y_d     = 26'sd0;
            win_cnt_d   = 8'd0;
            avg_x_d     = 18'd0;
            avg_y_d     = 18'd0;
            avg_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d_q     <= 1'b0;
            armed_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            last_x_q     <= 18'd0;
            last_y_q     <= 18'd0;
            sample_cnt_q <= 16'd0;
            state_q      <= S_IDLE;
            acc_x_q      <= 26'sd0;
            acc_y_q      <= 26'sd0;
            win_cnt_q    <= 8'd0;
            n_lat_q      <= 3'd0;
            avg_x_q      <= 18'd0;
            avg_y_q      <= 18'd0;
            avg_valid_q  <= 1'b0;
        end else begin
            done_d_q     <= done_d_d;
            armed_q      <= armed_d;
            s1_valid_q   <= s1_valid_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            sample_cnt_q <= sample_cnt_d;
            state_q      <= state_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            win_cnt_q    <= win_cnt_d;
            n_lat_q      <= n_lat_d;
            avg_x_q      <= avg_x_d;
            avg_y_q      <= avg_y_d;
            avg_valid_q  <= avg_valid_d;
        end
    end

    assign last_x     = last_x_q;
    assign last_y     = last_y_q;
    assign avg_x      = avg_x_q;
    assign avg_y      = avg_y_q;
    assign avg_valid  = avg_valid_q;
    assign sample_cnt = sample_cnt_q;
    assign busy       = (state_q == S_ACC) && (win_cnt_q != 8'd0);

endmodule

// File: tb/tb_ecs_sample_averager.sv
// Directed bench for ecs_sample_averager.
module tb_ecs_sample_averager;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [17:0] sensor_data_x = 18'd0;
    logic [17:0] sensor_data_y = 18'd0;
    logic [17:0] offset_x = 18'd0;
    logic [17:0] offset_y = 18'd0;
    logic [17:0] last_x, last_y, avg_x, avg_y;
    logic        avg_valid, busy;
    logic [15:0] sample_cnt;

    int checks = 0;
    int errors = 0;

    int mon_x[$];
    int mon_y[$];
    int prev_v = 0;

    ecs_sample_averager dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .done          (done),
        .sensor_data_x (sensor_data_x),
        .sensor_data_y (sensor_data_y),
        .enable        (enable),
        .clear         (clear),
        .avg_log2      (avg_log2),
        .offset_x      (offset_x),
        .offset_y      (offset_y),
        .last_x        (last_x),
        .last_y        (last_y),
        .avg_x         (avg_x),
        .avg_y         (avg_y),
        .avg_valid     (avg_valid),
        .sample_cnt    (sample_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record every published average; a strobe must never follow a strobe.
    always @(negedge clk) begin
        if (avg_valid) begin
            chk("avg_valid_single_cycle", prev_v, 0);
            mon_x.push_back($signed(avg_x));
            mon_y.push_back($signed(avg_y));
        end
        prev_v = int'(avg_valid);
    end

    function automatic int qx(input int i);
        return (i < mon_x.size()) ? mon_x[i] : -999999;
    endfunction

    function automatic int qy(input int i);
        return (i < mon_y.size()) ? mon_y[i] : -999999;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // done high for one cycle then low; returns in the cycle after edge t.
    task automatic do_sample(input int x, input int y);
        @(negedge clk);
        sensor_data_x = 18'(x);
        sensor_data_y = 18'(y);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic restart(input int l);
        enable = 1'b0;
        cyc(2);
        avg_log2 = 3'(l);
        enable = 1'b1;
        cyc(2);
        mon_x.delete();
        mon_y.delete();
    endtask

    initial begin
        // Reset with done and enable already high.
        done = 1'b1;
        enable = 1'b1;
        cyc(2);
        chk("rst_last_x", $signed(last_x), 0);
        chk("rst_avg_x", $signed(avg_x), 0);
        chk("rst_sample_cnt", int'(sample_cnt), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("stale_done_no_sample", int'(sample_cnt), 0);
        done = 1'b0;
        cyc(1);
        do_sample(3, -4);
        chk("first_cnt", int'(sample_cnt), 1);
        chk("first_last_x", $signed(last_x), 3);
        chk("first_last_y", $signed(last_y), -4);
        cyc(3);
        chk("first_avg_n", mon_x.size(), 1);
        chk("first_avg_x", qx(0), 3);
        chk("first_avg_y", qy(0), -4);

        // Saturation, X and Y in opposite directions.
        offset_x = 18'(-131072);
        offset_y = 18'(1);
        do_sample(131071, -131072);
        chk("sat_hi_x", $signed(last_x), 131071);
        chk("sat_lo_y", $signed(last_y), -131072);
        offset_x = 18'(1);
        offset_y = 18'(-131072);
        do_sample(-131072, 131071);
        chk("sat_lo_x", $signed(last_x), -131072);
        chk("sat_hi_y", $signed(last_y), 131071);
        offset_x = 18'(30);
        offset_y = 18'(-20);
        do_sample(100, -50);
        chk("offs_x", $signed(last_x), 70);
        chk("offs_y", $signed(last_y), -30);
        chk("sat_cnt", int'(sample_cnt), 4);
        offset_x = 18'd0;
        offset_y = 18'd0;
        cyc(3);

        // Floor rounding of a negative mean, with exact latency.
        restart(1);
        do_sample(-1, 4);
        do_sample(-2, 6);
        chk("floor_last_x", $signed(last_x), -2);
        cyc(1);
        chk("floor_t2_no_valid", int'(avg_valid), 0);
        cyc(1);
        chk("floor_t3_valid", int'(avg_valid), 1);
        chk("floor_avg_x", $signed(avg_x), -2);
        chk("floor_avg_y", $signed(avg_y), 5);
        cyc(1);
        chk("floor_valid_drop", int'(avg_valid), 0);

        // Full-scale 128-sample window.
        restart(7);
        for (int i = 0; i < 127; i++) do_sample(131071, -131072);
        chk("win128_no_early", mon_x.size(), 0);
        chk("win128_busy", int'(busy), 1);
        do_sample(131071, -131072);
        cyc(3);
        chk("win128_n", mon_x.size(), 1);
        chk("win128_avg_x", qx(0), 131071);
        chk("win128_avg_y", qy(0), -131072);

        // Window size change mid-window applies to the next window.
        restart(2);
        do_sample(10, -10);
        do_sample(20, -20);
        avg_log2 = 3'd0;
        do_sample(30, -30);
        do_sample(40, -40);
        cyc(3);
        do_sample(50, 1);
        cyc(3);
        do_sample(60, 2);
        cyc(3);
        chk("cfg_n", mon_x.size(), 3);
        chk("cfg_avg0_x", qx(0), 25);
        chk("cfg_avg0_y", qy(0), -25);
        chk("cfg_avg1_x", qx(1), 50);
        chk("cfg_avg2_x", qx(2), 60);
        chk("cfg_avg2_y", qy(2), 2);

        // enable dropped with a partial window.
        restart(2);
        do_sample(1, 1);
        do_sample(2, 2);
        do_sample(3, 3);
        cyc(2);
        chk("part_busy", int'(busy), 1);
        enable = 1'b0;
        cyc(3);
        chk("part_busy_off", int'(busy), 0);
        chk("part_no_valid", mon_x.size(), 0);
        chk("part_avg_x_kept", $signed(avg_x), 60);
        chk("part_avg_y_kept", $signed(avg_y), 2);

        // clear during EMIT with a sample arriving on the same edge.
        restart(1);
        do_sample(100, -100);
        do_sample(200, -200);
        @(negedge clk);
        clear = 1'b1;
        sensor_data_x = 18'(300);
        sensor_data_y = 18'(300);
        done = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        done = 1'b0;
        chk("clr_no_valid", int'(avg_valid), 0);
        chk("clr_cnt", int'(sample_cnt), 0);
        chk("clr_last_x", $signed(last_x), 0);
        chk("clr_last_y", $signed(last_y), 0);
        chk("clr_avg_x", $signed(avg_x), 0);
        chk("clr_avg_y", $signed(avg_y), 0);
        chk("clr_busy", int'(busy), 0);
        cyc(3);
        chk("clr_no_late_valid", mon_x.size(), 0);
        do_sample(8, -8);
        do_sample(12, -12);
        cyc(3);
        chk("clr_next_n", mon_x.size(), 1);
        chk("clr_next_avg_x", qx(0), 10);
        chk("clr_next_avg_y", qy(0), -10);
        chk("clr_next_cnt", int'(sample_cnt), 2);

        // Back-to-back samples two cycles apart with a one-sample window.
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        restart(0);
        do_sample(5, -5);
        do_sample(7, -7);
        do_sample(9, -9);
        cyc(4);
        chk("b2b_n", mon_x.size(), 3);
        chk("b2b_avg0", qx(0), 5);
        chk("b2b_avg1", qx(1), 7);
        chk("b2b_avg2", qx(2), 9);
        chk("b2b_avg2_y", qy(2), -9);
        chk("b2b_cnt", int'(sample_cnt), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecs_sample_averager.md
# ecs_sample_averager

Downstream consumer of the eddy-current SPI master. It detects each completed ADC transaction (rising edge of the master's `done` level) and latches the 18-bit signed X/Y readings. It applies per-axis offset correction with saturation, then block-averages 2^N corrected samples per axis. Results go to the AXI register file as per-axis averages with a one-cycle valid strobe, plus last-sample and sample-count status.

## Interface
- Parameters: none. Data width is fixed at 18 bits signed two's complement; the accumulator is 26 bits signed.
- `clk` input 1: system/AXI clock, same domain as the SPI master.
- `rst_n` input 1: asynchronous, active-low reset.
- `done` input 1: SPI master done level. It is high from transaction completion until the next `start`.
- `sensor_data_x`, `sensor_data_y` input 18 each: raw ADC words, two's complement. Valid whenever `done`=1.
- `enable` input 1: averaging enable, from a register.
- `clear` input 1: synchronous one-cycle pulse from a register write. Aborts the current window and zeroes all status.
- `avg_log2` input 3: window size is 2^avg_log2 samples (1..128).
- `offset_x`, `offset_y` input 18 each: signed offsets, subtracted from the raw data.
- `last_x`, `last_y` output 18: most recent offset-corrected sample.
- `avg_x`, `avg_y` output 18: most recent completed window average.
- `avg_valid` output 1: one-cycle strobe when `avg_x`/`avg_y` update.
- `sample_cnt` output 16: count of accepted samples; wraps.
- `busy` output 1: high while a window is partially accumulated.

## Operation
- **Edge detect.** `done_d` is registered every cycle, regardless of `enable`.
  - `sample` = `done` & ~`done_d`.
  - A `done` that is already high when `enable` rises does not produce a sample.
- **Stage 1 (correct).** On `sample` with `enable`=1:
  - diff = sext19(data) − sext19(offset).
  - Saturate to [−131072, 131071] and register into `last_x`/`last_y` with `s1_valid`.
  - Increment `sample_cnt` (modulo 2^16).
  - Samples arriving with `enable`=0 are ignored: no counter increment, no `last_*` update.
- **Stage 2 (accumulate).** When `s1_valid`=1:
  - `acc` += sext26(`last`).
  - `win_cnt` increments (8 bits).
- **State machine** (`IDLE`, `ACC`, `EMIT`):
  - `IDLE`: `acc`=0, `win_cnt`=0. `enable`=1 → `ACC`, latching `avg_log2` into `n_lat`.
  - `ACC`: when the `s1_valid` update makes `win_cnt` == 2^`n_lat` → `EMIT`. `busy` = (`win_cnt` != 0).
  - `EMIT` (one cycle):
    - `avg_x`/`avg_y` <= `acc` >>> `n_lat` (arithmetic shift, floor), truncated to 18 bits. This is lossless by construction.
    - `avg_valid`=1.
    - `acc`/`win_cnt` reset to 0 and `n_lat` re-latched from `avg_log2`.
    - Next state is `ACC` if `enable`, else `IDLE`.
- **Mid-window config change.** `avg_log2` changes mid-window take effect only at the next window start.
- **`enable` falling in `ACC`.**
  - Discard the partial window and go to `IDLE`.
  - `avg_*` keeps its last value; no `avg_valid`.
- **`clear`** has priority over everything, in any state:
  - go to `IDLE`, and drop any in-flight `s1_valid`;
  - zero `acc`, `win_cnt`, `sample_cnt`, `last_*`, `avg_*`;
  - no `avg_valid` that cycle.
- **Simultaneous events.** A `sample` coinciding with the `EMIT` cycle is not lost.
  - Its stage-1 result accumulates into the fresh window, because stage 2 sees `acc`=0 after `EMIT`.
  - Concretely, `EMIT` loads `acc` <= 0; an `s1_valid` in the same cycle loads `acc` <= sext(`last`) and `win_cnt` <= 1.

## Timing
- Reset values:
  - all outputs 0, state `IDLE`;
  - `done_d`=0, `s1_valid`=0, `acc`=0, `win_cnt`=0, `n_lat`=0.
- Let cycle t be the first clk edge sampling `done`=1 after `done`=0.
  - `last_*` and `sample_cnt` update at t+1.
  - `acc` updates at t+2.
  - If this sample completes the window, `avg_*`/`avg_valid` are visible at t+3.
- Throughput: one sample per 2 cycles minimum. The SPI master's done spacing (>80 cycles) is far slower than this, so no backpressure exists.
- `avg_valid` is never high on two consecutive cycles.
- Reset mid-operation: asynchronous return to the reset values above. The first `done` edge after release counts only if `done` was seen low after reset.

## Test plan
- **Reset and edge detect.**
  - Stimulus: hold `done`=1 through reset release with `enable`=1.
  - Required: no sample, `sample_cnt`=0. Drop and raise `done` → `sample_cnt`=1 at t+1.
- **Saturation.**
  - Stimulus: data=0x1FFFF, offset=−131072.
  - Required: `last`=131071.
  - Stimulus: data=0x20000, offset=1.
  - Required: `last`=−131072, with X and Y exercised independently.
- **Averaging and rounding.**
  - Stimulus: `avg_log2`=1, X samples −1 then −2.
  - Required: `avg_x`=−2 (floor of −1.5) at t+3 of the second edge; single-cycle `avg_valid`.
  - Stimulus: `avg_log2`=7 with 128 samples of 131071.
  - Required: `avg_x`=131071 (accumulator headroom check).
- **Window control.**
  - Stimulus: `avg_log2`=2, change to 0 after 2 samples.
  - Required: the first average is of 4 samples; subsequent averages are per-sample.
  - Stimulus: `enable` low after 3 of 4 samples.
  - Required: no `avg_valid`, `busy`=0, `avg_*` unchanged.
- **Clear priority.**
  - Stimulus: pulse `clear` in the same cycle as `EMIT`, with `s1_valid` pending.
  - Required: no `avg_valid`; all status zero; the next window starts empty.
- **Back-to-back.**
  - Stimulus: `avg_log2`=0, `done` edges 2 cycles apart, values 5, 7, 9 with offset 0.
  - Required: `avg_x` sequence 5, 7, 9; `sample_cnt`=3; no lost samples across `EMIT`.
